// File: rtl/msk_aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msk_aes_pkg: GF(2^8) helpers, InvMixColumns column function, FSM enc.  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package msk_aes_pkg;

  localparam logic [8:0] c_gf_poly = 9'h11B;
  localparam logic [7:0] c_imc_0e  = 8'h0E;
  localparam logic [7:0] c_imc_0b  = 8'h0B;
  localparam logic [7:0] c_imc_0d  = 8'h0D;
  localparam logic [7:0] c_imc_09  = 8'h09;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? c_gf_poly[7:0] : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Column packed as four bytes, row 0 in bits [7:0]; coefficients rotate per row.
  function automatic logic [31:0] inv_mc_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) a[r] = col[8*r +: 8];
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[8*r +: 8] = gf_mul_const(a[r], c_imc_0e)
                    ^ gf_mul_const(a[(r+1)%4], c_imc_0b)
                    ^ gf_mul_const(a[(r+2)%4], c_imc_0d)
                    ^ gf_mul_const(a[(r+3)%4], c_imc_09);
    end
    return res;
  endfunction

  function automatic int share_bit_idx(input int d, input int byte_i, input int bit_b, input int share_s);
    return 8*d*byte_i + d*bit_b + share_s;
  endfunction

  function automatic int col_base(input int d, input int col_c);
    return 32*d*col_c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msk_aes_inv_mc_serial_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msk_aes_inv_mc_serial_if: shared-state valid/ready bus                 |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
interface msk_aes_inv_mc_serial_if #(
  parameter int d = 2
) ();
  logic             in_valid;
  logic             in_ready;
  logic [128*d-1:0] sh_state_in;
  logic             out_valid;
  logic             out_ready;
  logic [128*d-1:0] sh_state_out;
  logic             busy;

  modport master (
    output in_valid, sh_state_in, out_ready,
    input  in_ready, out_valid, sh_state_out, busy
  );

  modport slave (
    input  in_valid, sh_state_in, out_ready,
    output in_ready, out_valid, sh_state_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/msk_aes_inv_mc_col.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msk_aes_inv_mc_col: share-wise InvMixColumns on one shared column      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module msk_aes_inv_mc_col
  import msk_aes_pkg::*;
#(
  parameter int d = 2
) (
  input  wire logic [32*d-1:0] i_col,
  output logic      [32*d-1:0] o_col
);

  // Each share is gathered, transformed and scattered on its own lanes only.
  for (genvar s = 0; s < d; s++) begin : g_share
    logic [31:0] w_plain;
    logic [31:0] w_res;

    for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar b = 0; b < 8; b++) begin : g_bit
        assign w_plain[8*r+b]                  = i_col[share_bit_idx(d, r, b, s)];
        assign o_col[share_bit_idx(d, r, b, s)] = w_res[8*r+b];
      end
    end

    assign w_res = inv_mc_col(w_plain);
  end

endmodule
`default_nettype wire

// File: rtl/msk_aes_inv_mc_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msk_aes_inv_mc_serial: masked InvMixColumns, one column per cycle      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module msk_aes_inv_mc_serial
  import msk_aes_pkg::*;
#(
  parameter int d = 2
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  msk_aes_inv_mc_serial_if.slave bus
);

  state_e            r_fsm;
  state_e            w_fsm_nxt;
  logic [1:0]        r_col_cnt;
  logic [128*d-1:0]  r_state;
  logic [32*d-1:0]   w_col_in;
  logic [32*d-1:0]   w_col_out;
  logic              w_in_ready;
  logic              w_load;

  // Column select comes only from the registered counter.
  assign w_col_in = r_state[col_base(d, int'(r_col_cnt)) +: 32*d];

  msk_aes_inv_mc_col #(
    .d (d)
  ) u_col (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_in_ready = 1'b0;
    w_load     = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load    = 1'b1;
          w_fsm_nxt = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (r_col_cnt == 2'd3) w_fsm_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_in_ready = 1'b1;
          if (bus.in_valid) begin
            w_load    = 1'b1;
            w_fsm_nxt = ST_COMPUTE;
          end else begin
            w_fsm_nxt = ST_IDLE;
          end
        end
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm     <= ST_IDLE;
      r_col_cnt <= '0;
      r_state   <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (w_load) begin
        r_state   <= bus.sh_state_in;
        r_col_cnt <= '0;
      end else if (r_fsm == ST_COMPUTE) begin
        r_state[col_base(d, int'(r_col_cnt)) +: 32*d] <= w_col_out;
        r_col_cnt <= r_col_cnt + 2'd1;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = (r_fsm == ST_DONE);
  assign bus.sh_state_out = r_state;
  assign bus.busy         = (r_fsm != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_msk_aes_inv_mc_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_msk_aes_inv_mc_serial: randomized bench with a GF(2^8) golden model |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_msk_aes_inv_mc_serial;

  localparam int D = 3;
  localparam int W = 128*D;
  typedef logic [D-1:0][127:0] shv_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] tin  [4] = '{32'hf8bd7e4d, 32'hd6d7d5d5, 32'h01010101, 32'hc6c6c6c6};
  logic [31:0] tout [4] = '{32'h4c31262d, 32'hd5d4d4d4, 32'h01010101, 32'hc6c6c6c6};

  always #5 clk = ~clk;

  msk_aes_inv_mc_serial_if #(.d(D)) bus ();

  msk_aes_inv_mc_serial #(.d(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int x, y, p;
    x = int'(a);
    y = int'(b);
    p = 0;
    while (y != 0) begin
      if (y % 2 == 1) p = p ^ x;
      x = x * 2;
      if (x > 255) x = x ^ 'h11B;
      y = y / 2;
    end
    return p[7:0];
  endfunction

  function automatic logic [127:0] col_mix(input logic [127:0] s, input logic [7:0] k0,
                                           input logic [7:0] k1, input logic [7:0] k2,
                                           input logic [7:0] k3);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[8*(4*c+r) +: 8];
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = gmul(a[r], k0) ^ gmul(a[(r+1)%4], k1)
                          ^ gmul(a[(r+2)%4], k2) ^ gmul(a[(r+3)%4], k3);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mc_ref(input logic [127:0] s);
    return col_mix(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic logic [127:0] mc_ref(input logic [127:0] s);
    return col_mix(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  function automatic logic [W-1:0] pack(input shv_t v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 8; b++)
        for (int s = 0; s < D; s++) r[8*D*i + D*b + s] = v[s][8*i+b];
    return r;
  endfunction

  function automatic logic [127:0] unmask(input logic [W-1:0] w);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 8; b++)
        for (int s = 0; s < D; s++) r[8*i+b] = r[8*i+b] ^ w[8*D*i + D*b + s];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic shv_t make_shares(input logic [127:0] value);
    shv_t v;
    v[0] = value;
    for (int s = 1; s < D; s++) begin
      v[s] = rand128();
      v[0] = v[0] ^ v[s];
    end
    return v;
  endfunction

  function automatic logic [W-1:0] expect_shares(input shv_t v);
    shv_t e;
    for (int s = 0; s < D; s++) e[s] = inv_mc_ref(v[s]);
    return pack(e);
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v);
    logic ok;
    ok = 1'b0;
    bus.sh_state_in = v;
    bus.in_valid    = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    check_eq("accept", W'(ok), W'(1'b1));
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input shv_t sh, input logic [127:0] exp_plain,
                         input int hold);
    int cyc;
    send(pack(sh));
    wait_out(cyc);
    check_eq({tag, "_lat"}, W'(cyc), W'(4));
    repeat (hold) tick();
    check_eq({tag, "_shares"}, bus.sh_state_out, expect_shares(sh));
    check_eq({tag, "_plain"}, W'(unmask(bus.sh_state_out)), W'(exp_plain));
    consume();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    shv_t         sh;
    shv_t         sh_b;
    logic [127:0] value;
    logic [127:0] expv;
    int           cyc;

    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.sh_state_in = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready", W'(bus.in_ready), W'(1'b1));
    check_eq("rst_out_valid", W'(bus.out_valid), W'(1'b0));
    check_eq("rst_busy", W'(bus.busy), W'(1'b0));
    check_eq("rst_out", bus.sh_state_out, '0);

    // Known vector with the mask share(s) zero.
    sh    = '0;
    sh[0] = {96'h0, 32'hbca14d8e};
    run_vec("kat0", sh, {96'h0, 32'h455313db}, 0);

    // Reference columns rotated through every column slot, random masks.
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        value[32*c +: 32] = tin[(c+k)%4];
        expv[32*c +: 32]  = tout[(c+k)%4];
      end
      run_vec($sformatf("kat_rot%0d", k), make_shares(value), expv, 0);
    end

    // Output stall: result holds, input side stays closed.
    sh = make_shares(rand128());
    send(pack(sh));
    wait_out(cyc);
    check_eq("stall_lat", W'(cyc), W'(4));
    for (int i = 0; i < 10; i++) begin
      bus.in_valid    = (i % 2 == 0);
      bus.sh_state_in = pack(make_shares(rand128()));
      @(negedge clk);
      check_eq("stall_valid", W'(bus.out_valid), W'(1'b1));
      check_eq("stall_in_ready", W'(bus.in_ready), W'(1'b0));
      check_eq("stall_data", bus.sh_state_out, expect_shares(sh));
      tick();
    end
    bus.in_valid = 1'b0;
    consume();
    check_eq("stall_idle_busy", W'(bus.busy), W'(1'b0));
    tick();
    check_eq("stall_no_accept", W'(bus.out_valid | bus.busy), W'(1'b0));

    // Back-to-back: output consumed in the same cycle the next state is accepted.
    sh   = make_shares(rand128());
    sh_b = make_shares(rand128());
    send(pack(sh));
    wait_out(cyc);
    check_eq("b2b_a_data", bus.sh_state_out, expect_shares(sh));
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.sh_state_in = pack(sh_b);
    @(negedge clk);
    check_eq("b2b_in_ready", W'(bus.in_ready), W'(1'b1));
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_eq("b2b_valid_drop", W'(bus.out_valid), W'(1'b0));
    check_eq("b2b_busy", W'(bus.busy), W'(1'b1));
    wait_out(cyc);
    check_eq("b2b_lat", W'(cyc), W'(4));
    check_eq("b2b_b_data", bus.sh_state_out, expect_shares(sh_b));
    consume();
    for (int i = 0; i < 3; i++) begin
      check_eq("b2b_no_dup", W'(bus.out_valid), W'(1'b0));
      tick();
    end

    // Asynchronous reset in the second COMPUTE cycle.
    send(pack(make_shares(rand128())));
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", W'(bus.out_valid), W'(1'b0));
    check_eq("mid_rst_busy", W'(bus.busy), W'(1'b0));
    check_eq("mid_rst_out", bus.sh_state_out, '0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_idle", W'(bus.busy), W'(1'b0));
    value = rand128();
    run_vec("post_rst", make_shares(value), inv_mc_ref(value), 0);

    // Random regression with variable output back-pressure.
    for (int n = 0; n < 1000; n++) begin
      value = rand128();
      run_vec("rand", make_shares(value), inv_mc_ref(value), $urandom_range(0, 2));
    end

    // Round trip: forward MixColumns result must come back to the original.
    for (int n = 0; n < 50; n++) begin
      value = rand128();
      run_vec("roundtrip", make_shares(mc_ref(value)), value, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
